// File: rtl/uart_rx_cfg.sv
// Run-time configurable UART receiver: 5-8 data bits, none/even/odd parity,
// 1 or 2 stop bits, 3-sample mid-bit majority vote, parity/frame/break flags.
module uart_rx_cfg #(
    parameter int CNT_W   = 16,
    parameter int MIN_CPB = 8
) (
    input  logic             i_Clock,
    input  logic             i_Reset_n,
    input  logic             i_Rx_Serial,
    input  logic [CNT_W-1:0] i_Clks_Per_Bit,
    input  logic [1:0]       i_Data_Bits,
    input  logic [1:0]       i_Parity,
    input  logic             i_Two_Stop,
    output logic             o_Rx_DV,
    output logic [7:0]       o_Rx_Byte,
    output logic             o_Parity_Err,
    output logic             o_Frame_Err,
    output logic             o_Break
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    localparam logic [CNT_W-1:0] MinCpb = CNT_W'(MIN_CPB);
    localparam logic [CNT_W-1:0] One    = CNT_W'(1);

    state_e state_q, state_d;

    logic             rx_meta_q, rx_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [1:0]       dbits_q, dbits_d;
    logic [1:0]       par_q, par_d;
    logic             two_q, two_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             stop_idx_q, stop_idx_d;
    logic             smp0_q, smp0_d;
    logic             smp1_q, smp1_d;
    logic [7:0]       data_q, data_d;
    logic             ones_q, ones_d;
    logic             any_one_q, any_one_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             dv_q, dv_d;
    logic [7:0]       byte_q, byte_d;
    logic             perr_o_q, perr_o_d;
    logic             ferr_o_q, ferr_o_d;
    logic             brk_o_q, brk_o_d;

    logic [CNT_W-1:0] n_req;
    logic [CNT_W-1:0] half;
    logic             at_lo, at_mid, at_vote, at_end;
    logic             maj;
    logic             last_bit, last_stop, par_en, timed;

    assign n_req     = (i_Clks_Per_Bit < MinCpb) ? MinCpb : i_Clks_Per_Bit;
    assign half      = n_q >> 1;
    assign at_lo     = (cnt_q == half - One);
    assign at_mid    = (cnt_q == half);
    assign at_vote   = (cnt_q == half + One);
    assign at_end    = (cnt_q == n_q - One);
    assign maj       = (smp0_q & smp1_q) | (smp0_q & rx_s_q) | (smp1_q & rx_s_q);
    assign last_bit  = (bit_idx_q == {1'b1, dbits_q});
    assign last_stop = (stop_idx_q == two_q);
    assign par_en    = (par_q == 2'b01) || (par_q == 2'b10);
    assign timed     = (state_q == S_START) || (state_q == S_DATA) ||
                       (state_q == S_PARITY) || (state_q == S_STOP);

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            n_q        <= MinCpb;
            dbits_q    <= 2'b11;
            par_q      <= 2'b00;
            two_q      <= 1'b0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            smp0_q     <= 1'b1;
            smp1_q     <= 1'b1;
            data_q     <= '0;
            ones_q     <= 1'b0;
            any_one_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_meta_q  <= i_Rx_Serial;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            dbits_q    <= dbits_d;
            par_q      <= par_d;
            two_q      <= two_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            smp0_q     <= smp0_d;
            smp1_q     <= smp1_d;
            data_q     <= data_d;
            ones_q     <= ones_d;
            any_one_q  <= any_one_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            dv_q     <= 1'b0;
            byte_q   <= '0;
            perr_o_q <= 1'b0;
            ferr_o_q <= 1'b0;
            brk_o_q  <= 1'b0;
        end else begin
            dv_q     <= dv_d;
            byte_q   <= byte_d;
            perr_o_q <= perr_o_d;
            ferr_o_q <= ferr_o_d;
            brk_o_q  <= brk_o_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (at_vote && maj) state_d = S_IDLE;
                else if (at_end)    state_d = S_DATA;
            end
            S_DATA: begin
                if (at_end && last_bit) state_d = par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (at_end) state_d = S_STOP;
            end
            S_STOP: begin
                // Final stop exits at its vote so a back-to-back start is seen
                if (at_vote && last_stop)
                    state_d = (ferr_q || !maj) ? S_WAIT_HIGH : S_IDLE;
            end
            S_WAIT_HIGH: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = '0;
        n_d        = n_q;
        dbits_d    = dbits_q;
        par_d      = par_q;
        two_d      = two_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        smp0_d     = smp0_q;
        smp1_d     = smp1_q;
        data_d     = data_q;
        ones_d     = ones_q;
        any_one_d  = any_one_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        dv_d       = 1'b0;
        byte_d     = byte_q;
        perr_o_d   = perr_o_q;
        ferr_o_d   = ferr_o_q;
        brk_o_d    = brk_o_q;

        if (timed) begin
            cnt_d = at_end ? '0 : cnt_q + One;
            if (at_lo)  smp0_d = rx_s_q;
            if (at_mid) smp1_d = rx_s_q;
        end

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    n_d        = n_req;
                    dbits_d    = i_Data_Bits;
                    par_d      = i_Parity;
                    two_d      = i_Two_Stop;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    data_d     = '0;
                    ones_d     = 1'b0;
                    any_one_d  = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            S_DATA: begin
                if (at_vote) begin
                    data_d[bit_idx_q] = maj;
                    ones_d            = ones_q ^ maj;
                    any_one_d         = any_one_q | maj;
                end
                if (at_end) bit_idx_d = bit_idx_q + 3'd1;
            end
            S_PARITY: begin
                if (at_vote) begin
                    any_one_d = any_one_q | maj;
                    perr_d    = (par_q == 2'b01) ? (ones_q ^ maj) : ~(ones_q ^ maj);
                end
            end
            S_STOP: begin
                if (at_vote) begin
                    if (!maj) ferr_d = 1'b1;
                    if (!stop_idx_q) any_one_d = any_one_q | maj;
                    if (last_stop) begin
                        dv_d     = 1'b1;
                        byte_d   = data_q;
                        perr_o_d = perr_q;
                        ferr_o_d = ferr_q | ~maj;
                        // Break only looks at the first stop bit
                        brk_o_d  = ~(any_one_q | (maj & ~stop_idx_q));
                    end
                end
                if (at_end) stop_idx_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_Rx_DV      = dv_q;
    assign o_Rx_Byte    = byte_q;
    assign o_Parity_Err = perr_o_q;
    assign o_Frame_Err  = ferr_o_q;
    assign o_Break      = brk_o_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: table of frames plus hand-built glitch, spike,
// break and reset sequences, checked through a strobe scoreboard.
module tb_uart_rx_cfg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic [15:0] cpb;
    logic [1:0]  dbits;
    logic [1:0]  par;
    logic        two;
    logic        dv;
    logic [7:0]  rbyte;
    logic        pe, fe, bk;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CNT_W(16), .MIN_CPB(8)) dut (
        .i_Clock       (clk),
        .i_Reset_n     (rst_n),
        .i_Rx_Serial   (rx),
        .i_Clks_Per_Bit(cpb),
        .i_Data_Bits   (dbits),
        .i_Parity      (par),
        .i_Two_Stop    (two),
        .o_Rx_DV       (dv),
        .o_Rx_Byte     (rbyte),
        .o_Parity_Err  (pe),
        .o_Frame_Err   (fe),
        .o_Break       (bk)
    );

    typedef struct packed {
        logic [7:0] b;
        logic       pe;
        logic       fe;
        logic       bk;
    } exp_t;

    typedef struct {
        logic [15:0] cpb;
        logic [1:0]  dbits;
        logic [1:0]  par;
        logic        two;
        logic [7:0]  data;
        logic        par_flip;
        logic        stop2;
        int          gap;
        int          spike;
        logic [7:0]  e_byte;
        logic        e_pe;
        logic        e_fe;
        logic        e_bk;
    } vec_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always @(negedge clk) begin : mon
        exp_t e;
        if (dv) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_strobe: got byte=%02h pe=%0b fe=%0b bk=%0b, required no strobe",
                         rbyte, pe, fe, bk);
            end else begin
                e = sb_q.pop_front();
                if ({rbyte, pe, fe, bk} !== e) begin
                    n_err++;
                    $display("FAIL frame_%02h: got byte=%02h pe=%0b fe=%0b bk=%0b, required byte=%02h pe=%0b fe=%0b bk=%0b",
                             e.b, rbyte, pe, fe, bk, e.b, e.pe, e.fe, e.bk);
                end
            end
        end
    end

    function automatic int neff(input logic [15:0] c);
        return (c < 16'd8) ? 8 : int'(c);
    endfunction

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string name, input logic [11:0] got, input logic [11:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %03h, required %03h", name, got, req);
        end
    endtask

    task automatic send_frame(input vec_t v);
        int         n;
        int         nb;
        logic [7:0] m;
        logic       p;
        cpb   = v.cpb;
        dbits = v.dbits;
        par   = v.par;
        two   = v.two;
        n     = neff(v.cpb);
        nb    = 5 + int'(v.dbits);
        if (v.gap > 0) drive(1'b1, v.gap * n);
        sb_q.push_back({v.e_byte, v.e_pe, v.e_fe, v.e_bk});
        drive(1'b0, n);
        cpb   = v.cpb + 16'd5;
        dbits = ~v.dbits;
        par   = v.par ^ 2'b11;
        two   = ~v.two;
        for (int i = 0; i < nb; i++) begin
            if (v.spike >= 0) begin
                drive(v.data[i], v.spike);
                drive(1'b0, 1);
                drive(v.data[i], n - v.spike - 1);
            end else begin
                drive(v.data[i], n);
            end
        end
        if (v.par == 2'b01 || v.par == 2'b10) begin
            m = 8'hFF >> (8 - nb);
            p = ^(v.data & m);
            if (v.par == 2'b10) p = ~p;
            drive(p ^ v.par_flip, n);
        end
        drive(1'b1, n);
        if (v.two) drive(v.stop2, n);
        cpb   = v.cpb;
        dbits = v.dbits;
        par   = v.par;
        two   = v.two;
    endtask

    vec_t tbl[8];
    vec_t hv;

    initial begin
        //           cpb   db     par    two   data   flip  stp2  gap spk  byte   pe    fe    bk
        tbl[0] = '{16'd16, 2'd3, 2'd0, 1'b0, 8'hA5, 1'b0, 1'b1, 2, -1, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'd16, 2'd3, 2'd0, 1'b0, 8'h3C, 1'b0, 1'b1, 0, -1, 8'h3C, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{16'd16, 2'd2, 2'd1, 1'b0, 8'h55, 1'b0, 1'b1, 1, -1, 8'h55, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{16'd16, 2'd2, 2'd1, 1'b0, 8'h55, 1'b1, 1'b1, 1, -1, 8'h55, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{16'd16, 2'd0, 2'd2, 1'b1, 8'h13, 1'b0, 1'b0, 1, -1, 8'h13, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{16'd16, 2'd0, 2'd2, 1'b1, 8'h0A, 1'b0, 1'b1, 2, -1, 8'h0A, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{16'd16, 2'd1, 2'd3, 1'b0, 8'h2D, 1'b0, 1'b1, 1, -1, 8'h2D, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{16'd0,  2'd3, 2'd0, 1'b0, 8'hC3, 1'b0, 1'b1, 2, -1, 8'hC3, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        rx    = 1'b1;
        cpb   = 16'd16;
        dbits = 2'd3;
        par   = 2'd0;
        two   = 1'b0;
        repeat (3) @(negedge clk);
        check_now("reset_byte", {4'h0, rbyte}, 12'h000);
        check_now("reset_flags", {8'h00, dv, pe, fe, bk}, 12'h000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 8);

        for (int i = 0; i < 8; i++) send_frame(tbl[i]);

        cpb   = 16'd16;
        dbits = 2'd3;
        par   = 2'd0;
        two   = 1'b0;
        drive(1'b1, 16);
        drive(1'b0, 4);
        drive(1'b1, 48);

        hv = '{16'd16, 2'd3, 2'd0, 1'b0, 8'hFF, 1'b0, 1'b1, 1, 9, 8'hFF, 1'b0, 1'b0, 1'b0};
        send_frame(hv);

        drive(1'b1, 32);
        sb_q.push_back({8'h00, 1'b0, 1'b1, 1'b1});
        drive(1'b0, 20 * 16);
        drive(1'b1, 32);
        hv = '{16'd16, 2'd3, 2'd0, 1'b0, 8'h81, 1'b0, 1'b1, 0, -1, 8'h81, 1'b0, 1'b0, 1'b0};
        send_frame(hv);

        drive(1'b1, 16);
        check_now("hold_byte", {4'h0, rbyte}, 12'h081);
        cpb = 16'd3;
        drive(1'b0, 8);
        drive(1'b0, 8);
        drive(1'b1, 8);
        drive(1'b1, 8);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_now("midrst_byte", {4'h0, rbyte}, 12'h000);
        check_now("midrst_flags", {8'h00, dv, pe, fe, bk}, 12'h000);
        rx = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 16);
        hv = '{16'd3, 2'd3, 2'd0, 1'b0, 8'h7E, 1'b0, 1'b1, 2, -1, 8'h7E, 1'b0, 1'b0, 1'b0};
        send_frame(hv);

        drive(1'b1, 64);
        check_now("pending_strobes", 12'(sb_q.size()), 12'h000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
